// File: rtl/mib_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mib_arb_pkg
// Description : Shared widths and FSM state encoding for the MIB command
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mib_arb_pkg;

  localparam int MIB_CMD_ADDR_W = 24;
  localparam int MIB_CMD_DATA_W = 32;
  localparam int MIB_ID_W       = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    DONE_ACK = 3'd3,
    DONE_TO  = 3'd4,
    GAP      = 3'd5
  } mib_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mib_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mib_rr_arbiter
// Description : Combinational round-robin winner select. The search starts
//               one past the last grant and wraps modulo P_NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module mib_rr_arbiter
  import mib_arb_pkg::*;
#(
  parameter int P_NUM_REQ = 4
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [MIB_ID_W-1:0]  i_last_grant,
  output logic                 o_valid,
  output logic [MIB_ID_W-1:0]  o_winner
);

  int w_best;
  int w_dist;

  // Pick the requesting index with the smallest rotated distance from last_grant+1.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_best   = P_NUM_REQ;
    w_dist   = 0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      w_dist = (k + 2 * P_NUM_REQ - int'(i_last_grant) - 1) % P_NUM_REQ;
      if (i_req[k] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = MIB_ID_W'(k);
        o_valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mib_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mib_cmd_arbiter
// Description : Shares one MIB master command port among P_NUM_REQ
//               requesters, one transaction at a time, round-robin, with a
//               local watchdog against a master that never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module mib_cmd_arbiter
  import mib_arb_pkg::*;
#(
  parameter int P_NUM_REQ   = 4,
  parameter int P_WDOG_CLKS = 256
) (
  input  logic                                i_sysclk,
  input  logic                                i_srst,
  input  logic [P_NUM_REQ-1:0]                i_req_sel,
  input  logic [P_NUM_REQ-1:0]                i_req_rd_wr_n,
  input  logic [P_NUM_REQ*MIB_CMD_ADDR_W-1:0] i_req_byte_addr,
  input  logic [P_NUM_REQ*MIB_CMD_DATA_W-1:0] i_req_wdata,
  output logic [P_NUM_REQ-1:0]                o_req_ack,
  output logic [P_NUM_REQ-1:0]                o_req_timeout,
  output logic [MIB_CMD_DATA_W-1:0]           o_req_rdata,
  output logic                                o_cmd_sel,
  output logic                                o_cmd_rd_wr_n,
  output logic [MIB_CMD_ADDR_W-1:0]           o_cmd_byte_addr,
  output logic [MIB_CMD_DATA_W-1:0]           o_cmd_wdata,
  input  logic [MIB_CMD_DATA_W-1:0]           i_cmd_rdata,
  input  logic                                i_cmd_ack,
  input  logic                                i_cmd_mib_timeout,
  output logic                                o_busy,
  output logic [MIB_ID_W-1:0]                 o_grant_id,
  output logic [15:0]                         o_wdog_cnt
);

  localparam int                  WD_W           = (P_WDOG_CLKS > 1) ? $clog2(P_WDOG_CLKS) : 1;
  localparam logic [WD_W-1:0]     WD_LAST        = WD_W'(P_WDOG_CLKS - 1);
  localparam logic [MIB_ID_W-1:0] LAST_GRANT_RST = MIB_ID_W'(P_NUM_REQ - 1);

  mib_arb_state_t              state_q, state_d;
  logic [MIB_ID_W-1:0]         last_grant_q, last_grant_d;
  logic [MIB_ID_W-1:0]         grant_q, grant_d;
  logic                        cmd_sel_q, cmd_sel_d;
  logic                        cmd_rd_wr_n_q, cmd_rd_wr_n_d;
  logic [MIB_CMD_ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [MIB_CMD_DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [P_NUM_REQ-1:0]        req_ack_q, req_ack_d;
  logic [P_NUM_REQ-1:0]        req_to_q, req_to_d;
  logic [MIB_CMD_DATA_W-1:0]   rdata_q, rdata_d;
  logic                        busy_q, busy_d;
  logic [WD_W-1:0]             wd_q, wd_d;
  logic [15:0]                 wdog_cnt_q, wdog_cnt_d;

  logic                        w_arb_valid;
  logic [MIB_ID_W-1:0]         w_arb_winner;
  logic                        w_mux_rd_wr_n;
  logic [MIB_CMD_ADDR_W-1:0]   w_mux_addr;
  logic [MIB_CMD_DATA_W-1:0]   w_mux_wdata;
  logic [P_NUM_REQ-1:0]        w_grant_oh;

  mib_rr_arbiter #(
    .P_NUM_REQ (P_NUM_REQ)
  ) u_rr (
    .i_req        (i_req_sel),
    .i_last_grant (last_grant_q),
    .o_valid      (w_arb_valid),
    .o_winner     (w_arb_winner)
  );

  // Select the winning requester's command fields and decode the held grant to one-hot.
  always_comb begin
    w_mux_rd_wr_n = 1'b0;
    w_mux_addr    = '0;
    w_mux_wdata   = '0;
    w_grant_oh    = '0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      if (w_arb_winner == MIB_ID_W'(k)) begin
        w_mux_rd_wr_n = i_req_rd_wr_n[k];
        w_mux_addr    = i_req_byte_addr[k*MIB_CMD_ADDR_W +: MIB_CMD_ADDR_W];
        w_mux_wdata   = i_req_wdata[k*MIB_CMD_DATA_W +: MIB_CMD_DATA_W];
      end
      w_grant_oh[k] = (grant_q == MIB_ID_W'(k));
    end
  end

  // Next-state and next-output logic; pulses are set on entry so they appear in the state's cycle.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    cmd_sel_d     = 1'b0;
    cmd_rd_wr_n_d = cmd_rd_wr_n_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    req_ack_d     = '0;
    req_to_d      = '0;
    rdata_d       = rdata_q;
    wd_d          = wd_q;
    wdog_cnt_d    = wdog_cnt_q;
    case (state_q)
      IDLE: begin
        if (w_arb_valid) begin
          state_d       = ISSUE;
          cmd_sel_d     = 1'b1;
          grant_d       = w_arb_winner;
          last_grant_d  = w_arb_winner;
          cmd_rd_wr_n_d = w_mux_rd_wr_n;
          cmd_addr_d    = w_mux_addr;
          cmd_wdata_d   = w_mux_wdata;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_cmd_ack) begin
          rdata_d   = i_cmd_rdata;
          req_ack_d = w_grant_oh;
          state_d   = DONE_ACK;
        end else if (i_cmd_mib_timeout) begin
          req_to_d = w_grant_oh;
          state_d  = DONE_TO;
        end else if (wd_q == WD_LAST) begin
          if (wdog_cnt_q != 16'hFFFF) begin
            wdog_cnt_d = wdog_cnt_q + 16'd1;
          end
          req_to_d = w_grant_oh;
          state_d  = DONE_TO;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE_ACK: state_d = GAP;
      DONE_TO:  state_d = GAP;
      GAP:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction without a completion pulse.
  always_ff @(posedge i_sysclk or posedge i_srst) begin
    if (i_srst) begin
      state_q       <= IDLE;
      last_grant_q  <= LAST_GRANT_RST;
      grant_q       <= '0;
      cmd_sel_q     <= 1'b0;
      cmd_rd_wr_n_q <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      req_ack_q     <= '0;
      req_to_q      <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      wd_q          <= '0;
      wdog_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      cmd_sel_q     <= cmd_sel_d;
      cmd_rd_wr_n_q <= cmd_rd_wr_n_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      req_ack_q     <= req_ack_d;
      req_to_q      <= req_to_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      wd_q          <= wd_d;
      wdog_cnt_q    <= wdog_cnt_d;
    end
  end

  assign o_req_ack       = req_ack_q;
  assign o_req_timeout   = req_to_q;
  assign o_req_rdata     = rdata_q;
  assign o_cmd_sel       = cmd_sel_q;
  assign o_cmd_rd_wr_n   = cmd_rd_wr_n_q;
  assign o_cmd_byte_addr = cmd_addr_q;
  assign o_cmd_wdata     = cmd_wdata_q;
  assign o_busy          = busy_q;
  assign o_grant_id      = grant_q;
  assign o_wdog_cnt      = wdog_cnt_q;

endmodule
`default_nettype wire
